ascon_perm_iter: RTL and testbench

- Sequential round engine wrapped around the combinational Ascon round (asconp); owns the 320-bit state register and iterates pa/pb permutations.
- Accepts a state plus a round count over valid/ready, applies one round per cycle (two with the optional unroll), and returns the permuted state over valid/ready.
- Sits between the Ascon RoCC/MMIO front-end (upstream) and the asconp round instance(s) (internal); it generates the rcon sequence that asconp consumes.

---
 rtl/ascon_perm_iter.sv | 165 ++++++++++++++++
 tb/tb_ascon_perm_iter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_perm_iter.sv
// Iterative Ascon permutation engine: accepts a 320-bit state over valid/ready and applies pa/pb rounds.
// Define ASCON_PERM_UNROLL2_EN to compute two rounds per cycle; results are bit-identical either way.

module asconp (
    input  logic [319:0] i_state,
    input  logic [3:0]   i_rcon,
    output logic [319:0] o_state
);
    logic [63:0] w_a0, w_a1, w_a2, w_a3, w_a4;
    logic [63:0] w_t0, w_t1, w_t2, w_t3, w_t4;
    logic [3:0]  w_idx;
    logic [7:0]  w_c;

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // rcon counts down: value k maps to round index 12-k, constant {~idx, idx}
    always_comb begin
        w_idx = 4'd12 - i_rcon;
        w_c   = {~w_idx, w_idx};
        w_a0  = i_state[319:256];
        w_a1  = i_state[255:192];
        w_a2  = i_state[191:128] ^ {56'd0, w_c};
        w_a3  = i_state[127:64];
        w_a4  = i_state[63:0];
        w_a0  = w_a0 ^ w_a4;
        w_a4  = w_a4 ^ w_a3;
        w_a2  = w_a2 ^ w_a1;
        w_t0  = ~w_a0 & w_a1;
        w_t1  = ~w_a1 & w_a2;
        w_t2  = ~w_a2 & w_a3;
        w_t3  = ~w_a3 & w_a4;
        w_t4  = ~w_a4 & w_a0;
        w_a0  = w_a0 ^ w_t1;
        w_a1  = w_a1 ^ w_t2;
        w_a2  = w_a2 ^ w_t3;
        w_a3  = w_a3 ^ w_t4;
        w_a4  = w_a4 ^ w_t0;
        w_a1  = w_a1 ^ w_a0;
        w_a0  = w_a0 ^ w_a4;
        w_a3  = w_a3 ^ w_a2;
        w_a2  = ~w_a2;
        o_state = {w_a0 ^ ror64(w_a0, 19) ^ ror64(w_a0, 28),
                   w_a1 ^ ror64(w_a1, 61) ^ ror64(w_a1, 39),
                   w_a2 ^ ror64(w_a2, 1)  ^ ror64(w_a2, 6),
                   w_a3 ^ ror64(w_a3, 10) ^ ror64(w_a3, 17),
                   w_a4 ^ ror64(w_a4, 7)  ^ ror64(w_a4, 41)};
    end
endmodule

module ascon_perm_iter #(
    parameter int unsigned MAX_ROUNDS = 12,
    parameter int unsigned STATE_W    = 320
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         rounds,
    input  logic [STATE_W-1:0] state_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] state_out,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam logic [3:0] L_MAX = 4'(MAX_ROUNDS);

    fsm_t               r_fsm;
    logic [3:0]         r_cnt;
    logic [STATE_W-1:0] r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic [3:0]         w_rounds_sat;
    logic [3:0]         w_cnt_nxt;
    logic [STATE_W-1:0] w_r0;
    logic [STATE_W-1:0] w_next;

    assign w_rounds_sat = (rounds > L_MAX) ? L_MAX : rounds;

    asconp u_round0 (
        .i_state (r_state),
        .i_rcon  (r_cnt),
        .o_state (w_r0)
    );

`ifdef ASCON_PERM_UNROLL2_EN
    logic [3:0]         w_cnt_m1;
    logic [STATE_W-1:0] w_r1;

    assign w_cnt_m1 = r_cnt - 4'd1;

    asconp u_round1 (
        .i_state (w_r0),
        .i_rcon  (w_cnt_m1),
        .o_state (w_r1)
    );

    // A lone final round skips the second stage so odd counts stay exact
    assign w_next    = (r_cnt == 4'd1) ? w_r0 : w_r1;
    assign w_cnt_nxt = (r_cnt == 4'd1) ? 4'd0 : r_cnt - 4'd2;
`else
    assign w_next    = w_r0;
    assign w_cnt_nxt = r_cnt - 4'd1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fsm       <= IDLE;
            r_cnt       <= '0;
            r_state     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_state    <= state_in;
                        r_cnt      <= w_rounds_sat;
                        r_in_ready <= 1'b0;
                        if (w_rounds_sat != 4'd0) begin
                            r_fsm  <= RUN;
                            r_busy <= 1'b1;
                        end else begin
                            r_fsm       <= DONE;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_state <= w_next;
                    r_cnt   <= w_cnt_nxt;
                    if (w_cnt_nxt == 4'd0) begin
                        r_fsm       <= DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_fsm       <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_fsm       <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign state_out = r_state;
endmodule

// File: tb/tb_ascon_perm_iter.sv
// Self-checking bench for ascon_perm_iter; reference permutation uses a table-driven S-box per bit column.
// Honours ASCON_PERM_UNROLL2_EN for expected latencies.

module tb_ascon_perm_iter;
    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   rounds;
    logic [319:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [319:0] state_out;
    logic         busy;

    int passed = 0;
    int total  = 0;

    localparam logic [319:0] IV_STATE = {64'h80400c0600000000, 64'h0001020304050607,
                                         64'h08090a0b0c0d0e0f, 64'h1011121314151617,
                                         64'h18191a1b1c1d1e1f};
    localparam logic [319:0] PAT = 320'h0123456789abcdef0123456789abcdef0123456789abcdef0123456789abcdef0123456789abcdef;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    ascon_perm_iter #(.MAX_ROUNDS(12), .STATE_W(320)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rounds    (rounds),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] model_perm(input logic [319:0] s, input int n);
        logic [63:0] x [5];
        logic [4:0]  col;
        logic [4:0]  o;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
        for (int r = 12 - n; r < 12; r++) begin
            x[2][7:0] = x[2][7:0] ^ 8'(((15 - r) << 4) | r);
            for (int b = 0; b < 64; b++) begin
                col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                o   = SBOX[col];
                x[0][b] = o[4]; x[1][b] = o[3]; x[2][b] = o[2]; x[3][b] = o[1]; x[4][b] = o[0];
            end
            x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
            x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
            x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
            x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
            x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic int lat(input int n);
`ifdef ASCON_PERM_UNROLL2_EN
        return (n + 1) / 2;
`else
        return n;
`endif
    endfunction

    task automatic accept(input logic [319:0] st, input logic [3:0] rnd);
        in_valid = 1'b1;
        state_in = st;
        rounds   = rnd;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    // Cycles from the accept edge until out_valid is seen; capped at 40
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clock); #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; rounds = '0; state_in = '0;
        #12;
        total++;
        if ({in_ready, out_valid, busy} !== 3'b100 || state_out !== '0)
            $display("FAIL reset_outputs: got rdy/vld/busy=%b state=%h want 100 / 0",
                     {in_ready, out_valid, busy}, state_out);
        else passed++;
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        total++;
        if ({in_ready, out_valid, busy} !== 3'b100)
            $display("FAIL reset_idle: got rdy/vld/busy=%b want 100", {in_ready, out_valid, busy});
        else passed++;
    endtask

    task automatic test_pa;
        int cyc;
        logic [319:0] exp_s;
        exp_s = model_perm('0, 12);
        out_ready = 1'b1;
        accept('0, 4'd12);
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL pa_accept: got in_ready=%b busy=%b want 0 1", in_ready, busy);
        else passed++;
        wait_done(cyc);
        total++;
        if (cyc !== lat(12)) $display("FAIL pa_latency: got %0d want %0d", cyc, lat(12));
        else passed++;
        total++;
        if (state_out !== exp_s) $display("FAIL pa_result: got %h want %h", state_out, exp_s);
        else passed++;
        @(posedge clock); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL pa_release: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic [319:0] e6, e8;
        e6 = model_perm(IV_STATE, 6);
        e8 = model_perm(IV_STATE, 8);
        out_ready = 1'b1;
        accept(IV_STATE, 4'd6);
        wait_done(cyc);
        total++;
        if (cyc !== lat(6) || state_out !== e6)
            $display("FAIL b2b_p6: got cyc=%0d state=%h want cyc=%0d state=%h", cyc, state_out, lat(6), e6);
        else passed++;
        in_valid = 1'b1; state_in = IV_STATE; rounds = 4'd8;
        @(posedge clock); #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL b2b_gap: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        else passed++;
        @(posedge clock); #1;
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0) $display("FAIL b2b_second_accept: got in_ready=%b want 0", in_ready);
        else passed++;
        wait_done(cyc);
        total++;
        if (cyc !== lat(8) || state_out !== e8)
            $display("FAIL b2b_p8: got cyc=%0d state=%h want cyc=%0d state=%h", cyc, state_out, lat(8), e8);
        else passed++;
        @(posedge clock); #1;
    endtask

    task automatic test_passthrough_saturation;
        int cyc;
        logic [319:0] e12;
        e12 = model_perm(IV_STATE, 12);
        out_ready = 1'b1;
        accept(PAT, 4'd0);
        wait_done(cyc);
        total++;
        if (cyc !== 0 || state_out !== PAT)
            $display("FAIL passthrough: got cyc=%0d state=%h want cyc=0 state=%h", cyc, state_out, PAT);
        else passed++;
        @(posedge clock); #1;
        accept(IV_STATE, 4'd15);
        wait_done(cyc);
        total++;
        if (cyc !== lat(12)) $display("FAIL sat_latency: got %0d want %0d", cyc, lat(12));
        else passed++;
        total++;
        if (state_out !== e12) $display("FAIL sat_result: got %h want %h", state_out, e12);
        else passed++;
        @(posedge clock); #1;
    endtask

    task automatic test_backpressure;
        int cyc;
        int errs;
        logic [319:0] exp_s;
        exp_s = model_perm(PAT, 6);
        out_ready = 1'b0;
        accept(PAT, 4'd6);
        wait_done(cyc);
        total++;
        if (cyc !== lat(6) || state_out !== exp_s)
            $display("FAIL bp_done: got cyc=%0d state=%h want cyc=%0d state=%h", cyc, state_out, lat(6), exp_s);
        else passed++;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            state_in = {10{$urandom()}};
            rounds   = 4'(i);
            @(posedge clock); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || state_out !== exp_s) errs++;
        end
        total++;
        if (errs != 0) $display("FAIL bp_hold: got %0d bad cycles of 20 want 0", errs);
        else passed++;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        else passed++;
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        logic [319:0] exp_s;
        exp_s = model_perm('0, 12);
        out_ready = 1'b1;
        accept(IV_STATE, 4'd12);
        repeat (4) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({in_ready, out_valid, busy} !== 3'b100 || state_out !== '0)
            $display("FAIL midrun_reset: got rdy/vld/busy=%b state=%h want 100 / 0",
                     {in_ready, out_valid, busy}, state_out);
        else passed++;
        #1 reset = 1'b0;
        @(posedge clock); #1;
        accept('0, 4'd12);
        wait_done(cyc);
        total++;
        if (cyc !== lat(12) || state_out !== exp_s)
            $display("FAIL after_reset_job: got cyc=%0d state=%h want cyc=%0d state=%h",
                     cyc, state_out, lat(12), exp_s);
        else passed++;
        @(posedge clock); #1;
    endtask

    task automatic test_odd_count;
        int cyc;
        logic [319:0] exp_s;
        exp_s = model_perm(IV_STATE, 5);
        out_ready = 1'b1;
        accept(IV_STATE, 4'd5);
        wait_done(cyc);
        total++;
        if (cyc !== lat(5)) $display("FAIL odd_latency: got %0d want %0d", cyc, lat(5));
        else passed++;
        total++;
        if (state_out !== exp_s) $display("FAIL odd_result: got %h want %h", state_out, exp_s);
        else passed++;
        @(posedge clock); #1;
    endtask

    initial begin
        test_reset();
        test_pa();
        test_back_to_back();
        test_passthrough_saturation();
        test_backpressure();
        test_reset_mid_run();
        test_odd_count();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
